// File: rtl/counter_arbiter_pkg.sv
// Shared types and constants for the two-requester counter arbiter.
package counter_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEFAULT_WIDTH = 4;

   localparam logic REQ0 = 1'b0;
   localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/counter_arbiter_count_core.sv
// WIDTH-bit up-counter with synchronous clear and count enable.
module count_core
   import counter_arbiter_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   output logic [WIDTH-1:0] q
);

   // Clear has priority so the arbiter can zero the counter in the same cycle it ends a run.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (en) begin
         q <= q + WIDTH'(1);
      end
   end

endmodule

// File: rtl/counter_arbiter.sv
// Round-robin owner of a shared counter: grants one requester a timed run from 0 to its length.
module counter_arbiter
   import counter_arbiter_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       req,
   input  logic [WIDTH-1:0] len0,
   input  logic [WIDTH-1:0] len1,
   output logic [1:0]       gnt,
   output logic             busy,
   output logic [WIDTH-1:0] q,
   output logic [1:0]       done
);

   state_t           state, next_state;
   logic             owner, next_owner;
   logic             last, next_last;
   logic [WIDTH-1:0] lim, next_lim;
   logic [1:0]       next_gnt, next_done;
   logic             next_busy;
   logic             clr, en;
   logic             win;

   count_core #(.WIDTH(WIDTH)) u_core (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .en  (en),
      .q   (q)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         owner <= REQ0;
         last  <= REQ1;
         lim   <= '0;
         gnt   <= '0;
         done  <= '0;
         busy  <= 1'b0;
      end else begin
         state <= next_state;
         owner <= next_owner;
         last  <= next_last;
         lim   <= next_lim;
         gnt   <= next_gnt;
         done  <= next_done;
         busy  <= next_busy;
      end
   end

   // Outputs are computed one cycle ahead and registered, so req/len never reach a port combinationally.
   always_comb begin
      next_state = state;
      next_owner = owner;
      next_last  = last;
      next_lim   = lim;
      next_gnt   = gnt;
      next_done  = '0;
      next_busy  = busy;
      clr        = 1'b0;
      en         = 1'b0;
      win        = (req == 2'b11) ? ~last : req[1];

      case (state)
         IDLE: begin
            clr = 1'b1;
            if (|req) begin
               next_state = RUN;
               next_owner = win;
               next_lim   = win ? len1 : len0;
               next_gnt   = win ? 2'b10 : 2'b01;
               next_busy  = 1'b1;
            end
         end
         RUN: begin
            if (!req[owner]) begin
               next_state = IDLE;
               next_gnt   = '0;
               next_busy  = 1'b0;
               next_last  = owner;
               clr        = 1'b1;
            end else if (q == lim) begin
               next_state = DONE;
               next_done  = owner ? 2'b10 : 2'b01;
            end else begin
               en = 1'b1;
            end
         end
         DONE: begin
            next_state = IDLE;
            next_gnt   = '0;
            next_busy  = 1'b0;
            next_last  = owner;
            clr        = 1'b1;
         end
         default: begin
            next_state = IDLE;
            next_gnt   = '0;
            next_busy  = 1'b0;
            clr        = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_counter_arbiter.sv
// Self-checking bench: vector table, directed corner cases and random traffic against a run-level model.
module tb_counter_arbiter;

   logic       clk;
   logic       rst;
   logic [1:0] req;
   logic [3:0] len0, len1;
   logic [1:0] gnt;
   logic       busy;
   logic [3:0] q;
   logic [1:0] done;

   int total = 0;
   int bad   = 0;

   // Model: a run is "active" for lim+2 cycles; t counts cycles since the grant edge.
   int m_active, m_owner, m_lim, m_t, m_last;

   typedef struct {
      logic [1:0] req;
      logic [3:0] l0;
      logic [3:0] l1;
      logic [1:0] gnt;
      logic       busy;
      logic [3:0] q;
      logic [1:0] done;
   } vec_t;

   vec_t vecs[10];

   counter_arbiter #(.WIDTH(4)) dut (
      .clk  (clk),
      .rst  (rst),
      .req  (req),
      .len0 (len0),
      .len1 (len1),
      .gnt  (gnt),
      .busy (busy),
      .q    (q),
      .done (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_active = 0;
      m_owner  = 0;
      m_lim    = 0;
      m_t      = 0;
      m_last   = 1;
   endtask

   task automatic model_step();
      if (m_active == 0) begin
         if (req != 2'b00) begin
            if (req == 2'b11) m_owner = 1 - m_last;
            else              m_owner = req[1] ? 1 : 0;
            m_active = 1;
            m_t      = 0;
            m_lim    = (m_owner == 1) ? int'(len1) : int'(len0);
         end
      end else if (m_t <= m_lim) begin
         if (!req[m_owner]) begin
            m_active = 0;
            m_last   = m_owner;
         end else begin
            m_t++;
         end
      end else begin
         m_active = 0;
         m_last   = m_owner;
      end
   endtask

   task automatic compare_model(input string tag);
      int eg, eb, eq, ed;
      eg = 0; eb = 0; eq = 0; ed = 0;
      if (m_active != 0) begin
         eg = 1 << m_owner;
         eb = 1;
         eq = (m_t <= m_lim) ? m_t : m_lim;
         ed = (m_t == m_lim + 1) ? (1 << m_owner) : 0;
      end
      checkOutput({tag, ".gnt"},  int'(gnt),  eg);
      checkOutput({tag, ".busy"}, int'(busy), eb);
      checkOutput({tag, ".q"},    int'(q),    eq);
      checkOutput({tag, ".done"}, int'(done), ed);
   endtask

   // Inputs are stable before the edge; outputs are sampled 1 ns after it.
   task automatic applyStimulus();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b0;
      #1;
      model_reset();
      compare_model(tag);
      #9;
      rst = 1'b1;
   endtask

   initial begin
      int   owners[$];
      logic [1:0] prev_gnt;
      int   maxq;
      int   saw_done;
      int   found;

      rst = 1'b1; req = 2'b00; len0 = 4'd0; len1 = 4'd0;
      model_reset();
      #2;
      do_reset("reset");

      vecs[0] = '{2'b01, 4'd3, 4'd0, 2'b01, 1'b1, 4'd0, 2'b00};
      vecs[1] = '{2'b01, 4'd3, 4'd0, 2'b01, 1'b1, 4'd1, 2'b00};
      vecs[2] = '{2'b01, 4'd3, 4'd0, 2'b01, 1'b1, 4'd2, 2'b00};
      vecs[3] = '{2'b01, 4'd3, 4'd0, 2'b01, 1'b1, 4'd3, 2'b00};
      vecs[4] = '{2'b01, 4'd3, 4'd0, 2'b01, 1'b1, 4'd3, 2'b01};
      vecs[5] = '{2'b00, 4'd3, 4'd0, 2'b00, 1'b0, 4'd0, 2'b00};
      vecs[6] = '{2'b01, 4'd0, 4'd0, 2'b01, 1'b1, 4'd0, 2'b00};
      vecs[7] = '{2'b01, 4'd0, 4'd0, 2'b01, 1'b1, 4'd0, 2'b01};
      vecs[8] = '{2'b00, 4'd0, 4'd0, 2'b00, 1'b0, 4'd0, 2'b00};
      vecs[9] = '{2'b00, 4'd0, 4'd0, 2'b00, 1'b0, 4'd0, 2'b00};

      for (int i = 0; i < 10; i++) begin
         req = vecs[i].req; len0 = vecs[i].l0; len1 = vecs[i].l1;
         applyStimulus();
         checkOutput($sformatf("vec%0d.gnt", i),  int'(gnt),  int'(vecs[i].gnt));
         checkOutput($sformatf("vec%0d.busy", i), int'(busy), int'(vecs[i].busy));
         checkOutput($sformatf("vec%0d.q", i),    int'(q),    int'(vecs[i].q));
         checkOutput($sformatf("vec%0d.done", i), int'(done), int'(vecs[i].done));
      end

      // Contention from a fresh reset: owners must alternate starting with requester 0.
      do_reset("reset2");
      req = 2'b11; len0 = 4'd2; len1 = 4'd1;
      prev_gnt = 2'b00;
      for (int c = 0; c < 16; c++) begin
         applyStimulus();
         compare_model("contend");
         if (gnt != 2'b00 && prev_gnt == 2'b00) owners.push_back(gnt[1] ? 1 : 0);
         prev_gnt = gnt;
      end
      checkOutput("contend.count", (owners.size() >= 3) ? 1 : 0, 1);
      if (owners.size() >= 3) begin
         checkOutput("contend.first",  owners[0], 0);
         checkOutput("contend.second", owners[1], 1);
         checkOutput("contend.third",  owners[2], 0);
      end
      req = 2'b00;
      for (int c = 0; c < 6; c++) applyStimulus();
      compare_model("contend.idle");

      // Full-length run for requester 1: counts to 15 without wrapping.
      req = 2'b10; len1 = 4'd15;
      maxq = 0; saw_done = 0;
      for (int c = 0; c < 25 && saw_done == 0; c++) begin
         applyStimulus();
         compare_model("len15");
         if (int'(q) > maxq) maxq = int'(q);
         if (done != 2'b00) begin
            saw_done = 1;
            req = 2'b00;
         end
      end
      checkOutput("len15.maxq", maxq, 15);
      checkOutput("len15.done_seen", saw_done, 1);
      applyStimulus();
      checkOutput("len15.q_after", int'(q), 0);

      // Abort: requester 0 drops at q=2 with requester 1 pending.
      req = 2'b01; len0 = 4'd5;
      applyStimulus();
      req = 2'b11;
      found = 0;
      for (int c = 0; c < 10 && found == 0; c++) begin
         applyStimulus();
         if (q == 4'd2) found = 1;
      end
      checkOutput("abort.reach_q2", found, 1);
      req = 2'b10;
      applyStimulus();
      checkOutput("abort.gnt",  int'(gnt),  0);
      checkOutput("abort.q",    int'(q),    0);
      checkOutput("abort.done", int'(done), 0);
      compare_model("abort");
      applyStimulus();
      checkOutput("abort.regrant", int'(gnt), 2);
      compare_model("abort.regrant");
      req = 2'b00;
      for (int c = 0; c < 4; c++) applyStimulus();

      // Asynchronous reset in the middle of a run.
      req = 2'b01; len0 = 4'd9;
      found = 0;
      for (int c = 0; c < 15 && found == 0; c++) begin
         applyStimulus();
         if (q == 4'd6) found = 1;
      end
      checkOutput("midrst.reach_q6", found, 1);
      #1;
      rst = 1'b0;
      #1;
      checkOutput("midrst.q",    int'(q),    0);
      checkOutput("midrst.gnt",  int'(gnt),  0);
      checkOutput("midrst.busy", int'(busy), 0);
      checkOutput("midrst.done", int'(done), 0);
      model_reset();
      #2;
      rst = 1'b1;
      applyStimulus();
      checkOutput("midrst.regrant", int'(gnt), 1);
      checkOutput("midrst.restart_q", int'(q), 0);
      req = 2'b00;
      for (int c = 0; c < 3; c++) applyStimulus();

      // Length changed after grant must not affect the run.
      req = 2'b01; len0 = 4'd4;
      applyStimulus();
      len0 = 4'd9;
      found = 0;
      for (int c = 0; c < 15 && found == 0; c++) begin
         applyStimulus();
         compare_model("lenchg");
         if (done != 2'b00) found = 1;
      end
      checkOutput("lenchg.done_seen", found, 1);
      checkOutput("lenchg.q_end", int'(q), 4);
      req = 2'b00;
      applyStimulus();

      // Random traffic against the model.
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 3) == 0) req = 2'($urandom_range(0, 3));
         len0 = 4'($urandom_range(0, 15));
         len1 = 4'($urandom_range(0, 15));
         applyStimulus();
         compare_model("rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/counter_arbiter.md
# counter_arbiter

Shares one synchronous up-counter between two requesters. Each requester asks for a timed count run of programmable length; the block grants round-robin, sequences the counter from 0 to the granted length, and signals completion with a one-cycle done pulse. It sits between the 4-bit counter datapath and its users, so the counter is never driven by two owners at once.

## Interface
- WIDTH, 4, counter and length width in bits
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-low; 0 clears all state immediately
- req  in  2  req[i] high = requester i wants a run; must be held until done[i]
- len0  in  WIDTH  terminal count for requester 0, sampled at grant
- len1  in  WIDTH  terminal count for requester 1, sampled at grant
- gnt  out  2  one-hot owner of the counter, zero when idle
- busy  out  1  high in RUN or DONE
- q  out  WIDTH  shared counter value
- done  out  2  done[i] is a one-cycle pulse at the end of requester i's run

## Operation
- Reset values: gnt=0, busy=0, q=0, done=0, state=IDLE, last-served pointer=1 (requester 0 is favoured first).
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - q held at 0.
  - If any req is high, choose the owner. A single requester wins outright. If both request, the one not last served wins.
  - Latch the owner's len into lim, set gnt[owner], move to RUN.
- RUN:
  - If req[owner] is low at the edge, abort: go to IDLE, q=0, gnt=0, no done pulse, pointer=owner.
  - Else if q==lim, go to DONE with q held.
  - Else q=q+1. The counter is unsigned modulo 2^WIDTH, but it never wraps because lim ≤ 2^WIDTH−1.
- DONE:
  - done[owner]=1 and gnt stays set for exactly one cycle.
  - At the next edge: IDLE, gnt=0, q=0, pointer=owner.
- len changes after grant are ignored; only lim is used.
- len=0: RUN lasts one cycle (q=0 matches lim), then DONE.
- len=2^WIDTH−1: q counts 0..15 with no wrap.
- A req from the non-owner during RUN or DONE is ignored and held pending. It is served at the next IDLE arbitration.
- An async reset mid-run drops everything to reset values with no done pulse. A requester still holding req is re-granted after reset deasserts.

## Timing
- req[i] high at edge k while in IDLE → after edge k: gnt[i]=1, busy=1, q=0.
- After edge k+n: q=n, for n ≤ lim.
- After edge k+lim+1: DONE state, done[i]=1, q=lim.
- After edge k+lim+2: IDLE, gnt=0, busy=0, done=0, q=0.
- A run occupies lim+2 cycles. There is at least one IDLE cycle between runs. Grant latency from req is 1 cycle.
- All outputs are registered. There is no combinational path from req or len to any output.

## Structure
- Package counter_arbiter_pkg holds:
  - state enum (IDLE, RUN, DONE)
  - default WIDTH constant
  - requester index constants
- Sub-module count_core:
  - WIDTH-bit synchronous counter with clr and en inputs, async active-low rst.
  - The arbiter FSM drives clr and en; q comes directly from count_core.

## Test plan
- Reset then single request: rst=0 for 10 ns then 1; req=01, len0=3 → gnt=01 one cycle later; q=0,1,2,3; done=01 pulse one cycle; gnt=00, q=0 after.
- Contention and fairness: req=11 held, len0=2, len1=1 → order is owner 0, then 1, then 0. done alternates 01/10. gnt is never 11.
- Boundary lengths: len0=0 → q stays 0, done after 2 cycles. len1=15 → q reaches 15, no wrap, done pulse, then q=0.
- Abort: req0 dropped while q=2 (lim=5) → next cycle gnt=00, q=0, no done. A pending req1 is granted on the following edge.
- Reset mid-run: rst=0 while q=6 → q, gnt, busy, done are 0 immediately (asynchronously). After rst=1 with req0 held, the run restarts from q=0.
- len change after grant: len0 changed from 4 to 9 during RUN → run still ends at q=4.
